alu_mul_sequencer: RTL and testbench

- Multi-cycle 16x16 unsigned multiplier built as the command side of the ALU interface.
- Drives A, B, FunSel and WF into the ALU and consumes its combinational result and registered flags.
- Uses ALU 16-bit ADD and LSL ops in a shift-add loop. Returns the low 16 product bits plus an overflow indication.
- Sits beside the ALU in the datapath, as a helper block the control unit invokes for MUL.

---
 rtl/alu_mul_sequencer.sv | 151 +++++++++++++++
 tb/tb_alu_mul_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/alu_mul_sequencer.sv
// Shift-add 16x16 unsigned multiplier that runs its arithmetic on the
// shared ALU. Each multiplier bit costs one SHIFT cycle, plus an ADD cycle
// when the bit is set. The ALU flags are registered, so the carry of an
// operation is read in the state that follows it.
module alu_mul_sequencer #(
    parameter logic [4:0] ADD_FUNSEL  = 5'b10100,
    parameter logic [4:0] LSL_FUNSEL  = 5'b11011,
    parameter logic [4:0] IDLE_FUNSEL = 5'b10000,
    parameter int unsigned CARRY_BIT  = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [15:0] multiplicand_i,
    input  logic [15:0] multiplier_i,
    input  logic [15:0] alu_out_i,
    input  logic [3:0]  flags_i,
    output logic [15:0] alu_a_o,
    output logic [15:0] alu_b_o,
    output logic [4:0]  alu_fun_sel_o,
    output logic        alu_wf_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] product_o,
    output logic        overflow_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_SHIFT,
        S_DONE
    } state_e;

    state_e      state_q, state_d;
    state_e      prev_q;          // state of the previous cycle; tells whose carry FlagsIn holds
    logic [15:0] acc_q, acc_d;
    logic [15:0] mcand_q, mcand_d;
    logic [15:0] mulr_q, mulr_d;
    logic        lost_q, lost_d;  // a set bit was shifted out of mcand earlier
    logic [15:0] product_q, product_d;
    logic        overflow_q, overflow_d;

    logic        carry;
    logic [15:0] mulr_next;

    assign carry     = flags_i[CARRY_BIT];
    assign mulr_next = mulr_q >> 1;

    // Next-state, datapath updates and ALU command for the current state.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d       = state_q;
        acc_d         = acc_q;
        mcand_d       = mcand_q;
        mulr_d        = mulr_q;
        lost_d        = lost_q;
        product_d     = product_q;
        overflow_d    = overflow_q;
        alu_a_o       = '0;
        alu_b_o       = '0;
        alu_fun_sel_o = IDLE_FUNSEL;
        alu_wf_o      = 1'b0;
        busy_o        = 1'b0;
        done_o        = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    acc_d      = '0;
                    mcand_d    = multiplicand_i;
                    mulr_d     = multiplier_i;
                    lost_d     = 1'b0;
                    overflow_d = 1'b0;
                    if (multiplier_i == '0)   state_d = S_DONE;
                    else if (multiplier_i[0]) state_d = S_ADD;
                    else                      state_d = S_SHIFT;
                end
            end

            S_ADD: begin
                busy_o        = 1'b1;
                alu_fun_sel_o = ADD_FUNSEL;
                alu_a_o       = acc_q;
                alu_b_o       = mcand_q;
                alu_wf_o      = 1'b1;
                acc_d         = alu_out_i;
                // Any multiplicand bit already shifted past bit 15 would have
                // been part of this addend, so the true product overflows.
                if (lost_q || (prev_q == S_SHIFT && carry)) overflow_d = 1'b1;
                state_d = S_SHIFT;
            end

            S_SHIFT: begin
                busy_o        = 1'b1;
                alu_fun_sel_o = LSL_FUNSEL;
                alu_a_o       = mcand_q;
                alu_b_o       = '0;
                alu_wf_o      = 1'b1;
                mcand_d       = alu_out_i;
                mulr_d        = mulr_next;
                if (prev_q == S_ADD && carry)   overflow_d = 1'b1;
                if (prev_q == S_SHIFT)          lost_d     = lost_q | carry;
                if (mulr_next == '0)   state_d = S_DONE;
                else if (mulr_next[0]) state_d = S_ADD;
                else                   state_d = S_SHIFT;
            end

            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase

        // Capture the result on the edge entering DONE so Product is already
        // valid while Done is high.
        if (state_d == S_DONE && state_q != S_DONE) product_d = acc_d;
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            prev_q     <= S_IDLE;
            acc_q      <= '0;
            mcand_q    <= '0;
            mulr_q     <= '0;
            lost_q     <= 1'b0;
            product_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values from before this edge, independent of statement order.
            state_q    <= state_d;
            prev_q     <= state_q;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            mulr_q     <= mulr_d;
            lost_q     <= lost_d;
            product_q  <= product_d;
            overflow_q <= overflow_d;
        end
    end

    assign product_o  = product_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer with a small behavioural ALU:
// combinational 16-bit ADD / LSL / pass-A and flags registered when WF=1.
module tb_alu_mul_sequencer;

    localparam logic [4:0] ADD_FS  = 5'b10100;
    localparam logic [4:0] LSL_FS  = 5'b11011;
    localparam logic [4:0] IDLE_FS = 5'b10000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] mcand, mulr;
    logic [15:0] alu_out;
    logic [3:0]  flags;
    logic [15:0] alu_a, alu_b;
    logic [4:0]  alu_fs;
    logic        alu_wf, busy, done, overflow;
    logic [15:0] product;
    logic        c_next;

    int n_checks = 0;
    int n_errors = 0;
    logic [4:0] fs_log [0:127];

    always #5 clk = ~clk;

    alu_mul_sequencer dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .start_i        (start),
        .multiplicand_i (mcand),
        .multiplier_i   (mulr),
        .alu_out_i      (alu_out),
        .flags_i        (flags),
        .alu_a_o        (alu_a),
        .alu_b_o        (alu_b),
        .alu_fun_sel_o  (alu_fs),
        .alu_wf_o       (alu_wf),
        .busy_o         (busy),
        .done_o         (done),
        .product_o      (product),
        .overflow_o     (overflow)
    );

    // Behavioural ALU result.
    always_comb begin
        alu_out = alu_a;
        c_next  = 1'b0;
        case (alu_fs)
            ADD_FS:  {c_next, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
            LSL_FS:  begin alu_out = {alu_a[14:0], 1'b0}; c_next = alu_a[15]; end
            default: begin alu_out = alu_a; c_next = 1'b0; end
        endcase
    end

    // ALU flags {Z,C,N,O}, written only when WF is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      flags <= '0;
        else if (alu_wf) flags <= {alu_out == 16'h0, c_next, alu_out[15], 1'b0};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One multiplication: Start for one cycle, wait for Done, check latency,
    // result, the single-cycle Done pulse and (optionally) ignored Start pulses.
    task automatic run_mul(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] exp_p, input logic exp_o, input int exp_lat,
                           input bit glitch);
        int lat;
        bit wf_seen;
        @(negedge clk);
        mcand = a;
        mulr  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        lat     = 1;
        wf_seen = 1'b0;
        while (!done && lat < 100) begin
            if (alu_wf) wf_seen = 1'b1;
            fs_log[lat] = alu_fs;
            if (glitch && (lat == 5 || lat == 20)) begin
                start = 1'b1;
                mcand = 16'h0003;
                mulr  = 16'h0001;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        check({tag, " latency"},  lat,      exp_lat);
        check({tag, " product"},  product,  exp_p);
        check({tag, " overflow"}, overflow, exp_o);
        check({tag, " busy@done"}, busy,    1'b0);
        if (b == 16'h0) check({tag, " wf_seen"}, wf_seen, 1'b0);
        @(posedge clk);
        #1;
        check({tag, " done one cycle"}, done, 1'b0);
        check({tag, " product held"},   product, exp_p);
    endtask

    initial begin
        logic [4:0] exp_seq [1:5];
        int first_done, second_done;

        rst_n = 1'b0;
        start = 1'b0;
        mcand = '0;
        mulr  = '0;
        #12;
        check("reset alu_fs",   alu_fs,   IDLE_FS);
        check("reset alu_wf",   alu_wf,   1'b0);
        check("reset product",  product,  16'h0);
        check("reset busy/done", {busy, done}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;

        // 3 x 5: ADD, SHIFT, SHIFT, ADD, SHIFT, DONE
        run_mul("3x5", 16'd3, 16'd5, 16'h000F, 1'b0, 6, 1'b0);
        exp_seq[1] = ADD_FS; exp_seq[2] = LSL_FS; exp_seq[3] = LSL_FS;
        exp_seq[4] = ADD_FS; exp_seq[5] = LSL_FS;
        for (int i = 1; i <= 5; i++) check($sformatf("3x5 funsel[%0d]", i), fs_log[i], exp_seq[i]);

        run_mul("0x1234x0",   16'h1234, 16'h0000, 16'h0000, 1'b0, 1,  1'b0);
        run_mul("FFFFx2",     16'hFFFF, 16'h0002, 16'hFFFE, 1'b1, 4,  1'b0);
        run_mul("100x100",    16'h0100, 16'h0100, 16'h0000, 1'b1, 11, 1'b0);
        run_mul("8000x3",     16'h8000, 16'h0003, 16'h8000, 1'b1, 5,  1'b0);
        run_mul("FFx101",     16'h00FF, 16'h0101, 16'hFFFF, 1'b0, 12, 1'b0);
        run_mul("FFFFxFFFF",  16'hFFFF, 16'hFFFF, 16'h0001, 1'b1, 33, 1'b1);

        // Start held high: 5 x 1 re-triggers on the IDLE cycle after DONE.
        first_done  = 0;
        second_done = 0;
        @(negedge clk);
        mcand = 16'd5;
        mulr  = 16'd1;
        start = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 7; cyc++) begin
            #1;
            if (done && first_done == 0)      first_done  = cyc;
            else if (done && second_done == 0) second_done = cyc;
            if (cyc == 7) start = 1'b0;
            @(posedge clk);
        end
        #1;
        check("hold first done",  first_done,  3);
        check("hold second done", second_done, 7);
        check("hold product",     product,     16'd5);

        // Reset in the middle of FFFF x FFFF.
        @(negedge clk);
        mcand = 16'hFFFF;
        mulr  = 16'hFFFF;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        check("pre-reset busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("async rst alu_a",    alu_a,    16'h0);
        check("async rst alu_b",    alu_b,    16'h0);
        check("async rst alu_fs",   alu_fs,   IDLE_FS);
        check("async rst wf",       alu_wf,   1'b0);
        check("async rst busy",     busy,     1'b0);
        check("async rst product",  product,  16'h0);
        check("async rst overflow", overflow, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("no done in reset", done, 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("no done after reset", done, 1'b0);

        run_mul("7x6", 16'd7, 16'd6, 16'h002A, 1'b0, 6, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
